// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: request/response handshake bundle between requesters and the shared comparator.
interface cmp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W = 4
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic rsp_gt;
  logic rsp_eq;
  logic rsp_lt;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt
  );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sequencer sharing one unsigned magnitude comparator among NREQ requesters.
module cmp_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  cmp_arbiter_if.slave bus,
  output logic busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] ptr, id_q, gnt_id, idx;
  logic gnt_any;
  logic [W-1:0] a_q, b_q, a_sel, b_sel;
  logic gt_q, eq_q, lt_q;
  // Walk downward so the requester closest to ptr is the last, winning, assignment.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
  end
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IW'(i)) begin
        a_sel = bus.req_a[i*W +: W];
        b_sel = bus.req_b[i*W +: W];
      end
    end
  end
  always_comb begin
    state_nxt = (state == IDLE) ? (gnt_any ? CMP : IDLE) :
                (state == CMP)  ? RESP :
                (bus.rsp_ready ? IDLE : RESP);
  end
  // Gated by rst_n so no grant is advertised while reset holds the block.
  assign bus.req_ready = (rst_n && state == IDLE && gnt_any) ? NREQ'(1) << gnt_id : '0;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id = id_q;
  assign bus.rsp_gt = gt_q;
  assign bus.rsp_eq = eq_q;
  assign bus.rsp_lt = lt_q;
  assign busy = (state != IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      gt_q <= 1'b0;
      eq_q <= 1'b1;
      lt_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gnt_any) begin
        a_q <= a_sel;
        b_q <= b_sel;
        id_q <= gnt_id;
      end
      if (state == CMP) begin
        gt_q <= a_q > b_q;
        eq_q <= a_q == b_q;
        lt_q <= a_q < b_q;
      end
      if (state == RESP && bus.rsp_ready) ptr <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: table vectors, directed corner sequences and a randomized transaction-level model.
module tb_cmp_arbiter;
  localparam int NREQ = 4;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;
  cmp_arbiter_if #(.NREQ(NREQ), .W(W)) bus();
  cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic gt;
    logic eq;
    logic lt;
  } vec_t;
  vec_t vecs[6];
  logic pend[NREQ];
  logic [W-1:0] opa[NREQ];
  logic [W-1:0] opb[NREQ];
  int ptr_m;
  int gid;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic post(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    opa[id] = a;
    opb[id] = b;
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_valid[id] = 1'b1;
  endtask
  // Starts in the accept cycle; returns at the start of the first cycle after the response.
  task automatic serve(input int id, input logic gt, input logic eq, input logic lt, input int hold);
    @(negedge clk);
    chk("grant", 32'(bus.req_ready), 32'(1 << id));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
    cyc();
    bus.req_valid[id] = 1'b0;
    @(negedge clk);
    chk("cmp_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("cmp_busy", 32'(busy), 1);
    chk("cmp_ready", 32'(bus.req_ready), 0);
    cyc();
    for (int h = 0; h <= hold; h++) begin
      bus.rsp_ready = (h == hold);
      @(negedge clk);
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(id));
      chk("rsp_flags", {29'd0, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, {29'd0, gt, eq, lt});
      chk("rsp_ready_low", 32'(bus.req_ready), 0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc();
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_flags", {29'd0, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 32'b010);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 0);
      chk("idle_rsp", 32'(bus.rsp_valid), 0);
      chk("idle_busy_r", 32'(busy), 0);
      cyc();
    end
    vecs[0] = '{4'd9, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'd5, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'd0, 4'd15, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'd15, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'd7, 4'd8, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      post(2, vecs[i].a, vecs[i].b);
      serve(2, vecs[i].gt, vecs[i].eq, vecs[i].lt, 0);
    end
    pulse_reset();
    for (int i = 0; i < NREQ; i++) post(i, W'($urandom), W'($urandom));
    for (int n = 0; n < 5; n++) begin
      gid = n % NREQ;
      serve(gid, opa[gid] > opb[gid], opa[gid] == opb[gid], opa[gid] < opb[gid], 0);
      post(gid, W'($urandom), W'($urandom));
    end
    bus.req_valid = '0;
    post(1, 4'd12, 4'd7);
    serve(1, 1'b1, 1'b0, 1'b0, 5);
    @(negedge clk);
    chk("bp_done_rsp", 32'(bus.rsp_valid), 0);
    chk("bp_done_busy", 32'(busy), 0);
    chk("bp_done_ready", 32'(bus.req_ready), 0);
    cyc();
    post(3, 4'd2, 4'd11);
    @(negedge clk);
    chk("mid_grant", 32'(bus.req_ready), 32'b1000);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_rsp", 32'(bus.rsp_valid), 0);
    chk("mid_reset_ready", 32'(bus.req_ready), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    post(1, 4'd6, 4'd6);
    serve(1, 1'b0, 1'b1, 1'b0, 0);
    serve(3, 1'b0, 1'b0, 1'b1, 0);
    bus.req_valid = '0;
    pulse_reset();
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 2 == 1)) begin
          pend[i] = 1'b1;
          post(i, W'($urandom), W'($urandom));
        end
      end
      gid = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (gid < 0 && pend[(ptr_m + k) % NREQ]) gid = (ptr_m + k) % NREQ;
      end
      if (gid < 0) begin
        @(negedge clk);
        chk("rand_idle_ready", 32'(bus.req_ready), 0);
        chk("rand_idle_busy", 32'(busy), 0);
        cyc();
      end else begin
        serve(gid, opa[gid] > opb[gid], opa[gid] == opb[gid], opa[gid] < opb[gid], $urandom_range(0, 2));
        pend[gid] = 1'b0;
        ptr_m = (gid + 1) % NREQ;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that time-shares one unsigned magnitude comparator among NREQ requesters. Each requester submits an (A, B) operand pair over a valid/ready handshake. The block grants one requester at a time, registers the operands, and evaluates the compare. It returns a one-hot greater/equal/less result, tagged with the requester index, over a response handshake. It sits between requesting control units and the shared compare datapath, so no requester needs its own comparator.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8)
- W, 4: operand width in bits (unsigned)

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NREQ  bit i: requester i has an operand pair pending
- req_a  input  NREQ*W  operand A; requester i uses bits [i*W +: W]
- req_b  input  NREQ*W  operand B; requester i uses bits [i*W +: W]
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumer accepts
- rsp_id  output  $clog2(NREQ)  index of the requester being answered
- rsp_gt  output  1  A > B
- rsp_eq  output  1  A == B
- rsp_lt  output  1  A < B
- busy  output  1  state is not IDLE

## Operation
- FSM states are IDLE, CMP and RESP. Reset state is IDLE.
- IDLE:
  - Grant goes to the first requester with req_valid set, searching upward from ptr modulo NREQ.
  - req_ready for that requester is combinational and is high this cycle only; all other bits are low.
  - On the clock edge, the block captures a_q, b_q and id_q, then moves to CMP.
  - If no req_valid bit is set, the block stays in IDLE and all req_ready bits stay low.
- CMP:
  - Unsigned compare of a_q against b_q.
  - The result is registered into gt_q, eq_q and lt_q, which are exactly one-hot.
  - Moves to RESP unconditionally.
- RESP:
  - rsp_valid is high. rsp_id, rsp_gt, rsp_eq and rsp_lt are driven from registers and stay stable while rsp_ready is low.
  - On rsp_valid & rsp_ready: ptr becomes (id_q+1) mod NREQ and the FSM goes to IDLE.
  - No new request is accepted while in CMP or RESP.
- The ptr update gives round-robin fairness. A requester that holds valid high is served within NREQ transactions.
- Requesters must hold req_valid, req_a and req_b stable until accepted. A requester that drops valid before acceptance is simply not granted.
- busy = (state != IDLE).

## Timing
- Reset values (asynchronous on rst_n low):
  - state = IDLE, ptr = 0, a_q = b_q = 0, id_q = 0
  - gt_q = 0, eq_q = 1, lt_q = 0
  - rsp_valid = 0, req_ready = 0, busy = 0
- Latency: accept at edge N (req_ready high in cycle N). rsp_valid rises in cycle N+2.
- Minimum issue interval is 3 cycles: accept, compare, respond with rsp_ready high. The next accept is possible in cycle N+3.
- Response backpressure: each cycle that rsp_ready is low during RESP adds one cycle. The outputs are held.
- Simultaneous requests: only the grant chosen from ptr proceeds. The others wait with req_ready low.
- Wrap-around: when id_q = NREQ-1, ptr becomes 0.
- Reset asserted mid-transaction: the block returns to IDLE asynchronously. The in-flight operation is dropped with no response. The first cycle after reset release is IDLE with ptr = 0.
- req_ready is never high outside IDLE. rsp_valid is never high outside RESP.

## Test plan
- Reset: hold rst_n low, then release with all req_valid = 0. Required: req_ready = 0, rsp_valid = 0, busy = 0, and the outputs stay idle indefinitely.
- Single request, one operand pair per case, rsp_ready held high, requester 2 (A = 4'd9, B = 4'd3; A = 4'd5, B = 4'd5; A = 4'd0, B = 4'd15):
  - First accept in cycle N. rsp_valid rises in cycle N+2 with rsp_id = 2.
  - Results: gt for 9 vs 3, then eq for 5 vs 5, then lt for 0 vs 15.
- Round-robin, all four valid, rsp_ready high:
  - Grants occur in order 0, 1, 2, 3, 0, spaced 3 cycles apart.
  - No requester is granted twice before all others are granted.
- Backpressure: hold rsp_ready low for 5 cycles in RESP.
  - rsp_valid stays high, with rsp_id and the flags unchanged.
  - req_ready stays 0 for all requesters.
  - The transaction completes one cycle after rsp_ready rises.
- Reset mid-transaction: assert rst_n low during CMP.
  - Immediately: busy = 0 and rsp_valid = 0.
  - After release, the pending requester 3 is served and the next grant search starts from 0.
